// File: rtl/aclk_key_ctrl_if.sv
// Keypad-side strobes and sequencer outputs for the alarm clock key controller.
interface aclk_key_ctrl_if;
  logic       one_second;
  logic       key_valid;
  logic [3:0] key;
  logic       shift;
  logic       load_alarm;
  logic       load_new_time;
  logic       show_alarm;
  logic       show_new_time;
  logic [2:0] digit_cnt;

  modport master (
    output one_second, key_valid, key,
    input  shift, load_alarm, load_new_time, show_alarm, show_new_time, digit_cnt
  );

  modport slave (
    input  one_second, key_valid, key,
    output shift, load_alarm, load_new_time, show_alarm, show_new_time, digit_cnt
  );
endinterface

// File: rtl/aclk_key_ctrl.sv
// Key-entry sequencer for the alarm clock: digit entry, alarm/time commit, alarm view.
// Inactivity timeout is built only when ACLK_KEY_TIMEOUT_EN is defined.
module aclk_key_ctrl #(
  parameter int TIMEOUT = 10
) (
  input logic            clock,
  input logic            reset,
  aclk_key_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY      = 2'd1,
    ALARM_VIEW = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [2:0] digit_cnt_r, digit_cnt_s;
  logic       shift_r, shift_s;
  logic       load_alarm_r, load_alarm_s;
  logic       load_new_time_r, load_new_time_s;
  logic       show_alarm_r, show_new_time_r;
  logic       is_digit_s, is_alarm_s, is_time_s, key_ok_s, timeout_s;

  assign is_digit_s = bus.key_valid && (bus.key <= 4'd9);
  assign is_alarm_s = bus.key_valid && (bus.key == 4'hA);
  assign is_time_s  = bus.key_valid && (bus.key == 4'hB);
  assign key_ok_s   = is_digit_s || is_alarm_s || is_time_s;

`ifdef ACLK_KEY_TIMEOUT_EN
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);
  logic [3:0] tmo_r, tmo_s;

  // A tick that coincides with a real key is discarded, so it can never time out.
  assign timeout_s = bus.one_second && !key_ok_s && (state_r != IDLE) && (tmo_r == TMO_LAST);

  // Inactivity counter next value.
  always_comb begin
    tmo_s = tmo_r;
    if (key_ok_s || (state_s != state_r)) begin
      tmo_s = 4'd0;
    end else if (bus.one_second && (state_r != IDLE)) begin
      tmo_s = tmo_r + 4'd1;
    end else begin
      tmo_s = tmo_r;
    end
  end

  // Inactivity counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_r <= 4'd0;
    end else begin
      tmo_r <= tmo_s;
    end
  end
`else
  logic unused_s;
  assign unused_s  = bus.one_second;
  assign timeout_s = 1'b0;
`endif

  // Next state, digit count and pulse decode.
  always_comb begin
    state_s         = state_r;
    digit_cnt_s     = digit_cnt_r;
    shift_s         = 1'b0;
    load_alarm_s    = 1'b0;
    load_new_time_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_digit_s) begin
          state_s     = ENTRY;
          shift_s     = 1'b1;
          digit_cnt_s = 3'd1;
        end else if (is_alarm_s) begin
          state_s = ALARM_VIEW;
        end else begin
          state_s = IDLE;
        end
      end
      ENTRY: begin
        if (is_digit_s) begin
          shift_s     = 1'b1;
          digit_cnt_s = (digit_cnt_r == 3'd4) ? 3'd4 : (digit_cnt_r + 3'd1);
        end else if (is_alarm_s && (digit_cnt_r == 3'd4)) begin
          load_alarm_s = 1'b1;
          state_s      = IDLE;
          digit_cnt_s  = 3'd0;
        end else if (is_time_s && (digit_cnt_r == 3'd4)) begin
          load_new_time_s = 1'b1;
          state_s         = IDLE;
          digit_cnt_s     = 3'd0;
        end else if (timeout_s) begin
          state_s     = IDLE;
          digit_cnt_s = 3'd0;
        end else begin
          state_s = ENTRY;
        end
      end
      ALARM_VIEW: begin
        // Any real key just leaves the view; a digit is swallowed, not shifted.
        if (key_ok_s || timeout_s) begin
          state_s = IDLE;
        end else begin
          state_s = ALARM_VIEW;
        end
      end
      default: begin
        state_s     = IDLE;
        digit_cnt_s = 3'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      digit_cnt_r     <= 3'd0;
      shift_r         <= 1'b0;
      load_alarm_r    <= 1'b0;
      load_new_time_r <= 1'b0;
      show_alarm_r    <= 1'b0;
      show_new_time_r <= 1'b0;
    end else begin
      state_r         <= state_s;
      digit_cnt_r     <= digit_cnt_s;
      shift_r         <= shift_s;
      load_alarm_r    <= load_alarm_s;
      load_new_time_r <= load_new_time_s;
      show_alarm_r    <= (state_s == ALARM_VIEW);
      show_new_time_r <= (state_s == ENTRY);
    end
  end

  assign bus.shift         = shift_r;
  assign bus.load_alarm    = load_alarm_r;
  assign bus.load_new_time = load_new_time_r;
  assign bus.show_alarm    = show_alarm_r;
  assign bus.show_new_time = show_new_time_r;
  assign bus.digit_cnt     = digit_cnt_r;

endmodule

// File: tb/tb_aclk_key_ctrl.sv
// Directed self-checking bench for aclk_key_ctrl (TIMEOUT = 10).
module tb_aclk_key_ctrl;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  aclk_key_ctrl_if bus ();

  aclk_key_ctrl #(.TIMEOUT(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Strobe one key for one edge; returns at the following negedge.
  task automatic press(input logic [3:0] k);
    bus.key       = k;
    bus.key_valid = 1'b1;
    @(negedge clock);
    bus.key_valid = 1'b0;
  endtask

  task automatic tick();
    bus.one_second = 1'b1;
    @(negedge clock);
    bus.one_second = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.key_valid  = 1'b0;
    bus.key        = 4'd0;
    bus.one_second = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_shift", 32'(bus.shift), 32'd0);
    check_eq("rst_cnt", 32'(bus.digit_cnt), 32'd0);
    check_eq("rst_show", 32'({bus.show_alarm, bus.show_new_time}), 32'd0);
    check_eq("rst_load", 32'({bus.load_alarm, bus.load_new_time}), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Digits 1..4 spaced three cycles apart
    for (int i = 0; i < 4; i++) begin
      press(4'(i + 1));
      check_eq("d_shift", 32'(bus.shift), 32'd1);
      check_eq("d_cnt", 32'(bus.digit_cnt), 32'(i + 1));
      check_eq("d_show_nt", 32'(bus.show_new_time), 32'd1);
      @(negedge clock);
      check_eq("d_shift_w", 32'(bus.shift), 32'd0);
      @(negedge clock);
    end

    // TIME commit
    press(4'hB);
    check_eq("t_load", 32'(bus.load_new_time), 32'd1);
    check_eq("t_cnt", 32'(bus.digit_cnt), 32'd0);
    check_eq("t_show_nt", 32'(bus.show_new_time), 32'd0);
    @(negedge clock);
    check_eq("t_load_w", 32'(bus.load_new_time), 32'd0);

    // Three digits then ALARM is refused; fourth digit then ALARM commits
    press(4'd5); press(4'd6); press(4'd7);
    press(4'hA);
    check_eq("a3_load", 32'(bus.load_alarm), 32'd0);
    check_eq("a3_show_nt", 32'(bus.show_new_time), 32'd1);
    check_eq("a3_cnt", 32'(bus.digit_cnt), 32'd3);
    press(4'd8);
    check_eq("a4_cnt", 32'(bus.digit_cnt), 32'd4);
    press(4'hA);
    check_eq("a4_load", 32'(bus.load_alarm), 32'd1);
    check_eq("a4_show_nt", 32'(bus.show_new_time), 32'd0);
    @(negedge clock);
    check_eq("a4_load_w", 32'(bus.load_alarm), 32'd0);

    // Alarm view and its timeout
    press(4'hA);
    check_eq("av_show", 32'(bus.show_alarm), 32'd1);
    repeat (9) tick();
    check_eq("av_9ticks", 32'(bus.show_alarm), 32'd1);
`ifdef ACLK_KEY_TIMEOUT_EN
    tick();
    check_eq("av_tmo", 32'(bus.show_alarm), 32'd0);
    press(4'hA);
    check_eq("av_again", 32'(bus.show_alarm), 32'd1);
`else
    repeat (11) tick();
    check_eq("av_20ticks", 32'(bus.show_alarm), 32'd1);
`endif
    press(4'd3);
    check_eq("av_exit", 32'(bus.show_alarm), 32'd0);
    check_eq("av_noshift", 32'(bus.shift), 32'd0);
    check_eq("av_cnt", 32'(bus.digit_cnt), 32'd0);

    // Six digits back to back
    for (int i = 0; i < 6; i++) begin
      bus.key       = 4'(i);
      bus.key_valid = 1'b1;
      @(negedge clock);
      check_eq("b2b_shift", 32'(bus.shift), 32'd1);
      check_eq("b2b_cnt", 32'(bus.digit_cnt), (i < 3) ? 32'(i + 1) : 32'd4);
    end
    bus.key_valid = 1'b0;
    @(negedge clock);
    check_eq("b2b_end", 32'(bus.shift), 32'd0);
    repeat (9) tick();
    check_eq("e_9ticks", 32'(bus.show_new_time), 32'd1);
`ifdef ACLK_KEY_TIMEOUT_EN
    // Key on the tenth tick wins and restarts the count
    bus.key        = 4'd7;
    bus.key_valid  = 1'b1;
    bus.one_second = 1'b1;
    @(negedge clock);
    bus.key_valid  = 1'b0;
    bus.one_second = 1'b0;
    check_eq("e_keytick", 32'(bus.show_new_time), 32'd1);
    check_eq("e_keytick_sh", 32'(bus.shift), 32'd1);
    repeat (9) tick();
    check_eq("e_restart", 32'(bus.show_new_time), 32'd1);
    // Ignored code on the timeout edge: timeout wins
    bus.key        = 4'hC;
    bus.key_valid  = 1'b1;
    bus.one_second = 1'b1;
    @(negedge clock);
    bus.key_valid  = 1'b0;
    bus.one_second = 1'b0;
    check_eq("e_tmo", 32'(bus.show_new_time), 32'd0);
    check_eq("e_tmo_cnt", 32'(bus.digit_cnt), 32'd0);
`else
    repeat (11) tick();
    check_eq("e_20ticks", 32'(bus.show_new_time), 32'd1);
    press(4'hB);
    check_eq("e_commit", 32'(bus.load_new_time), 32'd1);
`endif

    // Ignored code in IDLE
    press(4'hC);
    check_eq("idle_c", 32'({bus.show_alarm, bus.show_new_time, bus.shift}), 32'd0);

    // Reset during a shift pulse
    press(4'd1); press(4'd2);
    bus.key       = 4'd3;
    bus.key_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.key_valid = 1'b0;
    check_eq("r_pre_shift", 32'(bus.shift), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("r_shift", 32'(bus.shift), 32'd0);
    check_eq("r_show_nt", 32'(bus.show_new_time), 32'd0);
    check_eq("r_cnt", 32'(bus.digit_cnt), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    press(4'hB);
    check_eq("r_noload", 32'(bus.load_new_time), 32'd0);
    check_eq("r_idle", 32'(bus.show_new_time), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aclk_key_ctrl.md
# aclk_key_ctrl

Key-entry sequencer for the alarm clock: decodes debounced keypad strobes and drives the 4-digit key shift register's `shift` input plus the load and display-select strobes consumed by the alarm and time registers and the display mux. It sits between the keypad front end and the key register, alarm register and time counter. It enforces full 4-digit entry before any commit and abandons entry after an inactivity timeout.

## Interface
- `TIMEOUT`, default 10: one_second strobes of inactivity before entry or alarm display is abandoned (1..15).
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `one_second`  in  1  single-cycle 1 Hz tick strobe.
- `key_valid`  in  1  single-cycle strobe qualifying `key`.
- `key`  in  4  key code: 0–9 digit; 4'hA ALARM; 4'hB TIME; 4'hC–4'hF ignored.
- `shift`  out  1  one-cycle pulse; key register shifts in the current digit.
- `load_alarm`  out  1  one-cycle pulse; alarm register captures key register.
- `load_new_time`  out  1  one-cycle pulse; time counter captures key register.
- `show_alarm`  out  1  level; display selects the alarm register.
- `show_new_time`  out  1  level; display selects the key register.
- `digit_cnt`  out  3  digits entered this session, saturating at 4.

## Operation
- States: IDLE (show current time), ENTRY (digits being keyed), ALARM_VIEW.
- All outputs are registered. After reset: state IDLE and every output 0. The timeout counter is also 0.
- IDLE:
  - A digit goes to ENTRY, pulses `shift`, and sets `digit_cnt`=1.
  - ALARM goes to ALARM_VIEW.
  - TIME and codes C–F are ignored.
- ENTRY: `show_new_time`=1.
  - A digit pulses `shift` and increments `digit_cnt`, saturating at 4. The fifth and later digits still shift, so the register rolls and keeps the last 4 digits.
  - ALARM with `digit_cnt`==4 pulses `load_alarm` and goes to IDLE.
  - TIME with `digit_cnt`==4 pulses `load_new_time` and goes to IDLE.
  - ALARM or TIME with `digit_cnt`<4 is ignored; the state stays ENTRY and the timeout counter restarts.
- ALARM_VIEW: `show_alarm`=1.
  - Any valid key code 0–B returns to IDLE. That key is consumed and has no other effect; a digit does not shift.
- Timeout counter:
  - Cleared on every state change and on every accepted `key_valid` with code 0–B. Codes C–F do not clear it.
  - Increments on `one_second` in ENTRY and ALARM_VIEW.
  - Reaching TIMEOUT forces IDLE.
- Leaving ENTRY by commit or timeout clears `digit_cnt` to 0 and drops `show_new_time`.
- Leaving ALARM_VIEW drops `show_alarm`.
- `show_alarm` and `show_new_time` are never both 1.

## Timing
- `key_valid` sampled high at edge n: the corresponding `shift`, `load_*` or state change is visible after edge n, during cycle n+1. Latency is one cycle.
- Every pulse is exactly 1 cycle wide. Back-to-back `key_valid` on consecutive cycles gives back-to-back `shift` pulses with no loss.
- `key_valid` and `one_second` on the same edge: the key is processed, the counter clears, and the tick is discarded.
- `one_second` that brings the count to TIMEOUT: the state is IDLE and the show outputs are low after that same edge.
- `key_valid` with a C–F code on the timeout edge: the timeout still wins.
- `reset` asserted mid-operation, including during a pulse: all outputs go to 0 immediately and asynchronously. There are no pending pulses after release.
- Timeout counter width: 4 bits.

## Configuration
- `ACLK_KEY_TIMEOUT_EN` defined: inactivity timeout as described.
- Not defined: the counter logic is omitted and `one_second` is unused. ENTRY and ALARM_VIEW persist until a key event (commit, or any valid key in ALARM_VIEW).

## Test plan
- Reset then digits 1,2,3,4 with spacing 3 cycles -> four 1-cycle `shift` pulses, each one cycle after its strobe. `digit_cnt` reads 1,2,3,4 and `show_new_time`=1.
- 4 digits then TIME -> single `load_new_time` pulse the cycle after the strobe. State is IDLE with `digit_cnt`=0 and `show_new_time`=0.
- 3 digits then ALARM -> no `load_alarm` and state stays ENTRY. A 4th digit then ALARM -> one `load_alarm` pulse.
- IDLE, ALARM, then 9 `one_second` ticks -> `show_alarm` stays 1. The 10th tick clears `show_alarm` after that edge (macro defined). Without the macro, `show_alarm` stays 1 after 20 ticks.
- 6 digits back-to-back on consecutive cycles -> 6 consecutive `shift` pulses and `digit_cnt` saturates at 4. A `key_valid` simultaneous with `one_second` at tick 10 keeps ENTRY.
- Assert `reset` mid-ENTRY coincident with a `shift` pulse -> `shift`, `show_new_time` and `digit_cnt` go to 0 immediately. The next TIME key after release produces no `load_new_time`.
